// File: rtl/ib_ram_lut_loader_pkg.sv
// Shared definitions for the IB-RAM LUT write loader and the read-side RAM wrapper:
// page geometry helpers, the loader FSM states and the bank-slice placement.
package ib_ram_lut_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    // Pages per frame; the remaining address MSB selects the frame.
    function automatic int unsigned page_num(input int unsigned entry_addr);
        return 32'd1 << (entry_addr - 32'd1);
    endfunction

    function automatic int unsigned page_addr_w(input int unsigned entry_addr,
                                                input int unsigned frame_num);
        return entry_addr - $clog2(frame_num);
    endfunction

    // Bank 0 occupies the most significant slice of a page word.
    function automatic int unsigned bank_lsb(input int unsigned bank,
                                             input int unsigned port_size,
                                             input int unsigned bank_num);
        return port_size * (bank_num - 32'd1 - bank);
    endfunction

endpackage

// File: rtl/ib_ram_lut_loader.sv
// Packs streamed LUT half-words into page words and drives the IB-RAM write port,
// one frame per start pulse, with abort and done signalling.
module ib_ram_lut_loader
    import ib_ram_lut_loader_pkg::*;
#(
    parameter int unsigned QUAN_SIZE       = 3,
    parameter int unsigned ENTRY_ADDR      = 4,
    parameter int unsigned MULTI_FRAME_NUM = 2,
    parameter int unsigned BANK_NUM        = 2,
    parameter int unsigned LUT_PORT_SIZE   = 2
) (
    input  logic                              write_clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              load_frame,
    input  logic                              abort,
    input  logic [LUT_PORT_SIZE-1:0]          lut_in,
    input  logic                              lut_in_valid,
    output logic                              lut_in_ready,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
    output logic                              ib_ram_we,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned PAGE_NUM    = page_num(ENTRY_ADDR);
    localparam int unsigned PAGE_ADDR_W = page_addr_w(ENTRY_ADDR, MULTI_FRAME_NUM);
    localparam int unsigned WORD_W      = LUT_PORT_SIZE * BANK_NUM;
    localparam int unsigned BEAT_W      = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int unsigned LSB_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    if (MULTI_FRAME_NUM != 2 || QUAN_SIZE < 1) begin : g_param_check
        $error("ib_ram_lut_loader supports exactly two frames and a non-zero QUAN_SIZE");
    end

    ld_state_e               state_q, state_d;
    logic                    frame_q, frame_d;
    logic [PAGE_ADDR_W-1:0]  page_cnt_q, page_cnt_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [WORD_W-1:0]       pack_q, pack_d;
    logic                    we_q, we_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic [ENTRY_ADDR-1:0]   addr_q, addr_d;
    logic                    done_q, done_d;

    logic                    beat_accept;
    logic                    last_beat;
    logic                    last_page;
    logic [LSB_W-1:0]        slice_lsb;

    assign beat_accept = (state_q == LOAD) && lut_in_valid && !abort;
    assign last_beat   = (beat_cnt_q == BEAT_W'(BANK_NUM - 1));
    assign last_page   = (page_cnt_q == PAGE_ADDR_W'(PAGE_NUM - 1));
    assign slice_lsb   = LSB_W'(bank_lsb(32'(beat_cnt_q), LUT_PORT_SIZE, BANK_NUM));

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        page_cnt_d = page_cnt_q;
        beat_cnt_d = beat_cnt_q;
        pack_d     = pack_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        done_d     = 1'b0;

        if (beat_accept) begin
            pack_d[slice_lsb +: LUT_PORT_SIZE] = lut_in;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOAD;
                    frame_d    = load_frame;
                    page_cnt_d = '0;
                    beat_cnt_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (lut_in_valid) begin
                    if (last_beat) begin
                        we_d       = 1'b1;
                        wdata_d    = pack_d;
                        addr_d     = {frame_q, page_cnt_q};
                        beat_cnt_d = '0;
                        page_cnt_d = page_cnt_q + PAGE_ADDR_W'(1);
                        if (last_page) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                // First DONE cycle lets the final write retire; done pulses in the second.
                if (abort || done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= 1'b0;
            page_cnt_q <= '0;
            beat_cnt_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            page_cnt_q <= page_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
        end
    end

    // Every slice is rewritten before each page write, so the pack register needs no reset.
    always_ff @(posedge write_clk) begin
        pack_q <= pack_d;
    end

    assign lut_in_ready   = (state_q == LOAD);
    assign busy           = (state_q == LOAD) || ((state_q == DONE) && !done_q);
    assign done           = done_q;
    assign ib_ram_we      = we_q;
    assign page_addr_ram  = addr_q;
    assign ram_write_data = wdata_q;

endmodule

// File: tb/tb_ib_ram_lut_loader.sv
// Scoreboard bench for ib_ram_lut_loader: expected page writes are queued as beats are driven
// and checked against every ib_ram_we strobe.
module tb_ib_ram_lut_loader;

    logic       write_clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, load_frame, abort, lut_in_valid;
    logic [1:0] lut_in;
    logic       lut_in_ready, ib_ram_we, busy, done;
    logic [3:0] page_addr_ram;
    logic [3:0] ram_write_data;

    ib_ram_lut_loader #(
        .QUAN_SIZE(3), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2), .BANK_NUM(2), .LUT_PORT_SIZE(2)
    ) dut (
        .write_clk(write_clk), .rst(rst), .start(start), .load_frame(load_frame),
        .abort(abort), .lut_in(lut_in), .lut_in_valid(lut_in_valid),
        .lut_in_ready(lut_in_ready), .page_addr_ram(page_addr_ram),
        .ram_write_data(ram_write_data), .ib_ram_we(ib_ram_we), .busy(busy), .done(done)
    );

    always #5 write_clk = ~write_clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int exp_period = 0;
    logic [7:0] sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge write_clk);
        cyc++;
    end

    // Write monitor: pops one expected {addr,data} per strobe and checks write spacing.
    initial forever begin
        logic [7:0] e;
        @(negedge write_clk);
        if (ib_ram_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("we_unexpected", 32'(ib_ram_we), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("wr_addr", 32'(page_addr_ram), 32'(e[7:4]));
                check_val("wr_data", 32'(ram_write_data), 32'(e[3:0]));
            end
            if (exp_period != 0 && last_we_cyc >= 0)
                check_val("we_period", 32'(cyc - last_we_cyc), 32'(exp_period));
            last_we_cyc = cyc;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic start_pulse(input logic f);
        start = 1'b1;
        load_frame = f;
        tick();
        start = 1'b0;
        check_val("start_ready", 32'(lut_in_ready), 32'd1);
    endtask

    task automatic send_beat(input logic [1:0] v);
        int waited = 0;
        lut_in = v;
        lut_in_valid = 1'b1;
        while (lut_in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check_val("beat_accept_timeout", 32'(lut_in_ready), 32'd1);
        tick();
    endtask

    task automatic send_frame_beats(input logic f, input int nbeats, input int mul,
                                    input int seed, input bit toggle, input int start_on);
        logic [1:0] hi, v;
        hi = 2'd0;
        for (int i = 0; i < nbeats; i++) begin
            v = 2'((i * mul + seed) % 4);
            if (i % 2 == 0) hi = v;
            else sb_q.push_back({f, 3'(i / 2), hi, v});
            if (i == start_on) start = 1'b1;
            send_beat(v);
            start = 1'b0;
            if (toggle && i != nbeats - 1) begin
                lut_in_valid = 1'b0;
                tick();
            end
        end
        lut_in_valid = 1'b0;
    endtask

    task automatic expect_done();
        check_val("busy_during_last_we", 32'(busy), 32'd1);
        tick();
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("busy_at_done", 32'(busy), 32'd0);
        tick();
        check_val("done_cleared", 32'(done), 32'd0);
        check_val("ready_after_done", 32'(lut_in_ready), 32'd0);
    endtask

    initial begin
        int d0;
        start = 1'b0; load_frame = 1'b0; abort = 1'b0; lut_in_valid = 1'b0; lut_in = 2'd0;
        #1 rst = 1'b1;
        #2;
        check_val("rst_ready", 32'(lut_in_ready), 32'd0);
        check_val("rst_we", 32'(ib_ram_we), 32'd0);
        check_val("rst_addr", 32'(page_addr_ram), 32'd0);
        check_val("rst_data", 32'(ram_write_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Frame 1, continuous beats 0,1,2,3,...
        exp_period = 2; last_we_cyc = -1;
        start_pulse(1'b1);
        send_frame_beats(1'b1, 16, 1, 0, 1'b0, -1);
        expect_done();
        check_val("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Frame 0 with valid toggling every cycle
        exp_period = 4; last_we_cyc = -1;
        start_pulse(1'b0);
        send_frame_beats(1'b0, 16, 3, 1, 1'b1, -1);
        expect_done();
        check_val("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // start during LOAD is ignored
        exp_period = 2; last_we_cyc = -1; d0 = done_cnt;
        start_pulse(1'b0);
        send_frame_beats(1'b0, 16, 1, 2, 1'b0, 4);
        expect_done();
        repeat (4) tick();
        check_val("t3_idle_ready", 32'(lut_in_ready), 32'd0);
        check_val("t3_single_done", 32'(done_cnt - d0), 32'd1);

        // abort with page 2 half filled, then a clean frame 0
        exp_period = 0; d0 = done_cnt;
        start_pulse(1'b1);
        send_frame_beats(1'b1, 5, 1, 1, 1'b0, -1);
        lut_in = 2'd3; lut_in_valid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; lut_in_valid = 1'b0;
        check_val("t4_busy_after_abort", 32'(busy), 32'd0);
        check_val("t4_ready_after_abort", 32'(lut_in_ready), 32'd0);
        repeat (4) tick();
        check_val("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("t4_sb_empty", 32'(sb_q.size()), 32'd0);
        start_pulse(1'b0);
        send_frame_beats(1'b0, 16, 3, 2, 1'b0, -1);
        expect_done();

        // asynchronous reset while a write strobe is high
        start_pulse(1'b0);
        send_frame_beats(1'b0, 2, 1, 0, 1'b0, -1);
        send_beat(2'd2);
        send_beat(2'd3);
        lut_in_valid = 1'b0;
        check_val("t5_we_before_rst", 32'(ib_ram_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("t5_we_async", 32'(ib_ram_we), 32'd0);
        check_val("t5_busy_async", 32'(busy), 32'd0);
        check_val("t5_ready_async", 32'(lut_in_ready), 32'd0);
        check_val("t5_addr_async", 32'(page_addr_ram), 32'd0);
        tick();
        rst = 1'b0;
        lut_in = 2'd1; lut_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t5_idle_ready", 32'(lut_in_ready), 32'd0);
        end
        lut_in_valid = 1'b0;

        // start+abort together in IDLE
        start = 1'b1; abort = 1'b1; load_frame = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_val("t6_ready_stays_low", 32'(lut_in_ready), 32'd0);
        check_val("t6_busy_stays_low", 32'(busy), 32'd0);
        tick();
        check_val("t6_still_idle", 32'(lut_in_ready), 32'd0);
        exp_period = 2; last_we_cyc = -1;
        start_pulse(1'b1);
        send_frame_beats(1'b1, 16, 1, 3, 1'b0, -1);
        expect_done();

        tick();
        check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ib_ram_lut_loader.md
# ib_ram_lut_loader

Write-side loader for the symmetric IB-CNU LUT RAMs. It accepts a stream of LUT half-words from the iteration-update source (host/ROM sequencer) over a valid/ready handshake and packs one half-word per bank into a full page word. It then drives the RAM write port (page address with multi-frame offset bit, write data, write enable) that every CNU function RAM consumes. There is one loader per IB-RAM write group, sitting between the iteration-update controller and the `ib_ram_we` / `page_addr_ram` / `ram_write_data_*` fan-out.

## Interface
Parameters:
- QUAN_SIZE, 3, message width; not used internally, kept for parameter-list uniformity
- ENTRY_ADDR, 4, full page-address width; MSB is the multi-frame offset
- MULTI_FRAME_NUM, 2, number of frames; must be 2 (one offset bit)
- BANK_NUM, 2, banks per page word
- LUT_PORT_SIZE, 2, bits per bank per page

Ports (one clock; reset is asynchronous and active-high):
- write_clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begins loading one frame
- load_frame  in  1  frame (offset bit) to load; sampled with start
- abort  in  1  synchronous cancel of the current load
- lut_in  in  LUT_PORT_SIZE  half-word beat
- lut_in_valid  in  1  beat valid
- lut_in_ready  out  1  beat accepted when valid & ready
- page_addr_ram  out  ENTRY_ADDR  {frame, page}
- ram_write_data  out  LUT_PORT_SIZE*BANK_NUM  packed page word
- ib_ram_we  out  1  write strobe, one cycle per page
- busy  out  1  high from the edge after start until the edge before done
- done  out  1  one-cycle pulse after the final page write

## Operation
- PAGE_NUM = 2^(ENTRY_ADDR-1). Each page consumes BANK_NUM beats; each frame consumes PAGE_NUM*BANK_NUM beats (16 at defaults).
- Beat order within a page: beat 0 goes to bank0 = the most significant slice [LUT_PORT_SIZE*BANK_NUM-1 : LUT_PORT_SIZE*(BANK_NUM-1)]. Beat k goes to the slice k positions below bank0.
- Pages are written in ascending order 0..PAGE_NUM-1. page_addr_ram = {frame_reg, page_cnt}.
- FSM states and transitions:
  - IDLE: start → LOAD. Latch frame_reg ← load_frame; clear page_cnt and beat_cnt.
  - LOAD: each accepted beat is stored into the pack register and advances beat_cnt. On the BANK_NUM-th beat, the registered outputs fire: ib_ram_we=1, ram_write_data = the packed word including the current beat, page_addr_ram = {frame_reg, page_cnt}. page_cnt then increments. If this was the last page, the FSM goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- lut_in_ready = (state==LOAD); it is combinational from state only. Beats offered in IDLE or DONE are not consumed.
- start while busy or in DONE is ignored.
- abort in LOAD or DONE → IDLE at the next edge. The partial page is discarded, no write is issued on that edge, and done is not asserted. A beat presented in the abort cycle is not written.
- abort and start in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- ib_ram_we is deasserted every cycle that does not complete a page. ram_write_data and page_addr_ram hold their last values when we=0.

## Timing
- Reset values: lut_in_ready=0, ib_ram_we=0, page_addr_ram=0, ram_write_data=0, busy=0, done=0. State is IDLE and all counters are 0.
- start at edge t → state LOAD and lut_in_ready=1 from t+1.
- Final beat of page p accepted at edge n → ib_ram_we=1 with page p during cycle n+1.
- Write throughput is one page per BANK_NUM cycles with continuous valid. lut_in_valid gaps stall with no lost data.
- Final beat of the frame at edge n → we high in cycle n+1, done high in cycle n+2 (busy low in n+2), IDLE in n+3.
- Minimum start-to-done is PAGE_NUM*BANK_NUM+2 cycles.
- rst mid-load: all outputs return to reset values immediately (asynchronously) and the partial frame is abandoned.

## Structure
- Shared package: PAGE_NUM and PAGE_ADDR_W = ENTRY_ADDR-$clog2(MULTI_FRAME_NUM), the FSM state enum {IDLE, LOAD, DONE}, and the bank-slice index function. The package is shared with the read-side RAM wrapper.
- No sub-module is required. An optional `lut_beat_packer` (beat_cnt plus shift/pack register) is permitted if reuse is wanted.

## Test plan
- Reset release, then start with load_frame=1 and 16 continuous beats 0,1,2,3,0,1,... → 8 writes at addrs 8..15. Each data word = {beat0,beat1} (e.g. 4'b0001, 4'b1011). done arrives 2 cycles after the last beat.
- Frame 0 with lut_in_valid toggling 1/0 every cycle → same 8 writes at addrs 0..7. One write every 4 cycles, no beat lost or duplicated.
- start asserted on the 5th LOAD cycle → ignored. Writes continue unchanged and exactly one done is produced.
- abort after 5 beats (page 2 half-filled) → no further we and no done. busy=0 next cycle. A following start/frame 0 writes page 0 first with fresh data.
- rst pulsed during cycle with we=1 → ib_ram_we, busy, lut_in_ready fall asynchronously. After release, the FSM sits in IDLE, ignores beats, and ready=0.
- Simultaneous start+abort in IDLE → FSM stays in IDLE, ready stays 0. start alone next cycle begins loading normally.
